// File: rtl/load_store_unit_pkg.sv
// ----------------------------------------------------------------------------
// load_store_unit_pkg : access-size codes, FSM states, legality helper (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int CNT_W           = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Halfwords need an even address, words a word-aligned one; other codes are illegal.
  function automatic logic access_legal(input logic [2:0] func3, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (func3)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = ~addr_lo[0];
      F3_W:        ok = (addr_lo == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ----------------------------------------------------------------------------
// lsu_lane_align : byte strobes, lane replication and load extract/extend (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    wstrb   = 4'b1111;
    wdata   = st_data;
    shifted = ld_word >> {addr_lo, 3'b000};
    ld_data = shifted;
    case (func3)
      F3_B, F3_BU: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{st_data[7:0]}};
      end
      F3_H, F3_HU: begin
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
    case (func3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data = {24'd0, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit : core-to-bus load/store sequencer with timeout (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_RD,
  input  logic        MEM_WRT,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] ADDR,
  input  logic [31:0] W_DATA,
  output logic [31:0] R_DATA,
  output logic        STALL,
  output logic        MISALIGN,
  output logic        BUS_ERR,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [3:0]  BUS_WSTRB,
  output logic [31:0] BUS_WDATA,
  input  logic        BUS_GNT,
  input  logic        BUS_RVALID,
  input  logic [31:0] BUS_RDATA
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       func3_q, func3_d;
  logic [1:0]       addr_lo_q, addr_lo_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [3:0]       bus_wstrb_q, bus_wstrb_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [31:0]      r_data_q, r_data_d;

  logic        in_idle, request, legal, busy, timeout_hit;
  logic [2:0]  align_func3;
  logic [1:0]  align_addr_lo;
  logic [3:0]  align_wstrb;
  logic [31:0] align_wdata, align_ld_data;

  assign in_idle     = (state_q == ST_IDLE);
  assign request     = MEM_RD | MEM_WRT;
  assign legal       = access_legal(FUNC3, ADDR[1:0]);
  assign busy        = (state_q == ST_REQ) | (state_q == ST_WAIT);
  assign timeout_hit = busy & (cnt_q == CNT_LAST);

  // Live inputs drive the aligner while accepting; latched ones while the load returns.
  assign align_func3   = in_idle ? FUNC3 : func3_q;
  assign align_addr_lo = in_idle ? ADDR[1:0] : addr_lo_q;

  lsu_lane_align u_align (
    .func3   (align_func3),
    .addr_lo (align_addr_lo),
    .st_data (W_DATA),
    .ld_word (BUS_RDATA),
    .wstrb   (align_wstrb),
    .wdata   (align_wdata),
    .ld_data (align_ld_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    func3_d     = func3_q;
    addr_lo_d   = addr_lo_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    r_data_d    = r_data_q;
    case (state_q)
      ST_IDLE: begin
        if (request && legal) begin
          state_d     = ST_REQ;
          cnt_d       = '0;
          func3_d     = FUNC3;
          addr_lo_d   = ADDR[1:0];
          bus_req_d   = 1'b1;
          bus_we_d    = MEM_WRT;
          bus_addr_d  = {ADDR[31:2], 2'b00};
          bus_wstrb_d = MEM_WRT ? align_wstrb : 4'b0000;
          bus_wdata_d = align_wdata;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 1'b1;
        // An expiring timeout beats a grant arriving in the same cycle.
        if (timeout_hit) begin
          state_d   = ST_DONE;
          bus_req_d = 1'b0;
          r_data_d  = '0;
        end else if (BUS_GNT) begin
          state_d   = ST_WAIT;
          bus_req_d = 1'b0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (BUS_RVALID) begin
          state_d = ST_DONE;
          if (!bus_we_q) r_data_d = align_ld_data;
        end else if (timeout_hit) begin
          state_d  = ST_DONE;
          r_data_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      func3_q     <= '0;
      addr_lo_q   <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
      r_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      func3_q     <= func3_d;
      addr_lo_q   <= addr_lo_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      r_data_q    <= r_data_d;
    end
  end

  assign STALL     = (in_idle & request & legal) | busy;
  assign MISALIGN  = in_idle & request & ~legal;
  assign BUS_ERR   = timeout_hit & ~((state_q == ST_WAIT) & BUS_RVALID);
  assign R_DATA    = r_data_q;
  assign BUS_REQ   = bus_req_q;
  assign BUS_WE    = bus_we_q;
  assign BUS_ADDR  = bus_addr_q;
  assign BUS_WSTRB = bus_wstrb_q;
  assign BUS_WDATA = bus_wdata_q;

endmodule

`default_nettype wire
